// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, frame width, and the
// clocks-per-bit helper used to size the bit timer.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_e;

  localparam int DATA_BITS = 8;

  // Integer clk cycles per bit. The result must be >= 8 so that the three
  // vote samples and the start-bit midpoint land on distinct counter values.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// UART receive-side bundle.
//   rx        : asynchronous serial line, idle high
//   rx_data   : last correctly received byte
//   rx_valid  : one-cycle pulse, rx_data updated
//   frame_err : one-cycle pulse, stop bit sampled low
//   busy      : a frame is in progress
// master = the receiver, slave = the line driver / byte consumer.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (input rx, output rx_data, rx_valid, frame_err, busy);
  modport slave  (output rx, input rx_data, rx_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer plus one edge-detect flop for an asynchronous input.
// All flops reset to 1 (idle-high line), so a low line at reset release is
// never reported as a falling edge.
//   clk, rst  : clock, synchronous active-high reset
//   async_in  : asynchronous input
//   sync_out  : synchronized level (rx_s)
//   fall_edge : sync_out just went 1 -> 0
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic fall_edge
);

  // [0] metastability stage, [1] rx_s, [2] rx_s_d
  logic [2:0] sh_q, sh_d;

  always_comb sh_d = {sh_q[1:0], async_in};

  always_ff @(posedge clk) begin
    if (rst) sh_q <= '1;
    else     sh_q <= sh_d;
  end

  assign sync_out  = sh_q[1];
  assign fall_edge = sh_q[2] & ~sh_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Validates the start bit at its midpoint, takes each data
// bit and the stop bit as a 3-sample majority vote at the end of its bit
// window, then pulses rx_valid (good stop) or frame_err (stop low).
//   clk, rst : clock, synchronous active-high reset
//   bus      : uart_rx_if.master (rx in; rx_data/rx_valid/frame_err/busy out)
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  uart_rx_if.master  bus
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t CNT_HALF = cnt_t'(HALF - 1);
  localparam cnt_t CNT_S0   = cnt_t'(CLKS_PER_BIT - 3);
  localparam cnt_t CNT_S1   = cnt_t'(CLKS_PER_BIT - 2);
  localparam cnt_t CNT_LAST = cnt_t'(CLKS_PER_BIT - 1);
  localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

  logic rx_s, fall_edge;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .async_in  (bus.rx),
    .sync_out  (rx_s),
    .fall_edge (fall_edge)
  );

  rx_state_e            state_q, state_d;
  cnt_t                 clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 vote;

  // Third vote sample is the live rx_s at the decision cycle.
  assign vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    smp_d       = smp_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fall_edge) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end

      START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          // Still low at mid-start: real frame; otherwise a glitch, drop it.
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      DATA, STOP: begin
        if (clk_cnt_q == CNT_S0) smp_d[0] = rx_s;
        if (clk_cnt_q == CNT_S1) smp_d[1] = rx_s;
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          if (state_q == DATA) begin
            shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
            if (bit_idx_q == IDX_LAST) state_d = STOP;
            else                       bit_idx_d = bit_idx_q + 1'b1;
          end else begin
            // Leave at mid-stop so a start bit right after the stop bit is caught.
            if (vote) begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      smp_q       <= '1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      smp_q       <= smp_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected frames into a queue,
// a negedge monitor pops and compares on every rx_valid / frame_err pulse.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int C = 104;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if bus ();

  uart_rx #(.CLK_FREQ(1000000), .BAUD_RATE(9600)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   valid_cyc = 0;
  int   last_busy_cyc = 0;
  int   last_lat = 0;
  int   n_valid = 0;
  int   n_ferr = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  function automatic void check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void check_range(input string name, input longint act, input longint lo,
                                      input longint hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) last_busy_cyc <= cyc;
      if (bus.rx_valid && bus.frame_err) check("pulse_overlap", 1, 0);
      if (bus.rx_valid || bus.frame_err) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_pulse", {bus.frame_err, bus.rx_data}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_kind", bus.frame_err, mon_e.err);
          if (!mon_e.err) check("sb_data", bus.rx_data, mon_e.data);
        end
      end
      if (bus.rx_valid) begin
        n_valid   <= n_valid + 1;
        valid_cyc <= cyc;
        last_lat  <= cyc - start_cyc;
      end
      if (bus.frame_err) n_ferr <= n_ferr + 1;
    end
  end

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int cpb, input bit spike);
    for (int i = 0; i < cpb; i++) begin
      bus.rx = (spike && i == cpb / 2) ? ~v : v;
      @(negedge clk);
    end
  endtask

  // Full 8N1 frame; spike_bit selects a data bit that gets a 1-clk inverted spike.
  task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop_v,
                           input int spike_bit);
    exp_t e;
    e.err  = ~stop_v;
    e.data = b;
    exp_q.push_back(e);
    start_cyc = cyc;
    drive_bit(1'b0, cpb, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i], cpb, spike_bit == i);
    drive_bit(stop_v, cpb, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int bad, nv, nf, bcnt;
    bus.rx = 1'b1;

    // Reset and quiet line
    do_reset(5);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_busy", bus.busy, 0);
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.rx_data != 8'h00 || bus.rx_valid || bus.frame_err || bus.busy) bad++;
      @(negedge clk);
    end
    check("idle_quiet_cycles_bad", bad, 0);

    // Single frame: data, latency, busy release
    nv = n_valid;
    send_byte(8'hA5, C, 1'b1, -1);
    idle(100);
    check("single_valid_count", n_valid - nv, 1);
    check("single_rx_data", bus.rx_data, 8'hA5);
    check_range("single_latency", last_lat, 9 * C + C / 2 + 3 - 2, 9 * C + C / 2 + 3 + 2);
    check_range("single_busy_fall", last_busy_cyc - valid_cyc, -3, 3);
    check("single_no_ferr", n_ferr, 0);

    // Back-to-back, zero idle gap
    nv = n_valid;
    send_byte(8'h00, C, 1'b1, -1);
    send_byte(8'hFF, C, 1'b1, -1);
    send_byte(8'h3C, C, 1'b1, -1);
    idle(100);
    check("b2b_valid_count", n_valid - nv, 3);
    check("b2b_no_ferr", n_ferr, 0);
    check("b2b_last_data", bus.rx_data, 8'h3C);

    // Short start glitch
    nv = n_valid;
    nf = n_ferr;
    bus.rx = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 220; i++) begin
      if (i == 20) bus.rx = 1'b1;
      @(negedge clk);
      if (bus.busy) bcnt++;
    end
    check_range("glitch_busy_cycles", bcnt, 1, 55);
    check("glitch_no_valid", n_valid - nv, 0);
    check("glitch_no_ferr", n_ferr - nf, 0);

    // Slow transmitter with a mid-bit spike on bit 2
    nv = n_valid;
    send_byte(8'hC3, C + 2, 1'b1, 2);
    idle(100);
    check("spike_valid_count", n_valid - nv, 1);
    check("spike_rx_data", bus.rx_data, 8'hC3);

    // Framing error, line held low, then recovery
    do_reset(2);
    nv = n_valid;
    nf = n_ferr;
    send_byte(8'h5A, C, 1'b0, -1);
    bcnt = 0;
    for (int i = 0; i < 300; i++) begin
      bus.rx = 1'b0;
      @(negedge clk);
      if (bus.busy) bcnt++;
    end
    idle(50);
    check("ferr_count", n_ferr - nf, 1);
    check("ferr_no_valid", n_valid - nv, 0);
    check("ferr_low_hold_busy", bcnt, 0);
    check("ferr_rx_data_held", bus.rx_data, 8'h00);
    send_byte(8'h81, C, 1'b1, -1);
    idle(100);
    check("ferr_recover_data", bus.rx_data, 8'h81);
    check("ferr_recover_valid", n_valid - nv, 1);

    // Reset during bit 4 of 0x77; the aborted frame is never reported
    nv = n_valid;
    begin
      logic [7:0] b;
      b = 8'h77;
      drive_bit(1'b0, C, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(b[i], C, 1'b0);
      drive_bit(b[4], C / 2, 1'b0);
    end
    rst = 1'b1;
    bus.rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy_after", bus.busy, 0);
    idle(1200);
    check("midrst_no_valid", n_valid - nv, 0);
    send_byte(8'h12, C, 1'b1, -1);
    idle(100);
    check("midrst_valid_count", n_valid - nv, 1);
    check("midrst_rx_data", bus.rx_data, 8'h12);

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver: the consumer stage for the serial line driven by our UART transmitter. It synchronizes the asynchronous rx pin and validates the start bit at mid-bit. It samples 8 data bits LSB-first with 3-sample majority voting and checks the stop bit. It then presents the byte with a one-cycle valid pulse, or flags a framing error. Sits between the pad/loopback and the byte-level consumer (FIFO or scoreboard).

Parameters:
CLK_FREQ, 1000000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bit/s
CLKS_PER_BIT (localparam), CLK_FREQ/BAUD_RATE = 104, clk cycles per bit; must be >= 8
HALF (localparam), CLKS_PER_BIT/2 = 52, start-bit mid-point

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line, idle high
rx_data  output  8  last correctly received byte
rx_valid  output  1  one-cycle pulse: rx_data updated
frame_err  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (synchronous, rst=1 at posedge clk):
  - sync flops <= 1, state <= IDLE, counters 0.
  - rx_data=8'h00, rx_valid=0, frame_err=0, busy=0.
  - Reset mid-frame abandons the frame; no pulse is produced.
- Synchronizer: 2 flops give rx_s; a third flop gives rx_s_d.
- Start detection: a falling edge is rx_s_d=1 and rx_s=0. Only a falling edge starts a frame; a line held low never retriggers.
- Counters: clk_cnt counts 0..CLKS_PER_BIT-1; bit_idx is 0..7.
- Vote: majority of the 3 rx_s samples taken at clk_cnt = C-3, C-2, C-1, where C = CLKS_PER_BIT. The decision is made at C-1.
- IDLE: on a falling edge, go to START with clk_cnt=0.
- START:
  - When clk_cnt=HALF-1, sample rx_s.
  - If 0: go to DATA, clk_cnt=0, bit_idx=0.
  - If 1 (glitch): go to IDLE silently.
- DATA:
  - At each vote: shreg <= {vote, shreg[7:1]}, clk_cnt=0.
  - After bit_idx=7, go to STOP; otherwise bit_idx++.
- STOP (vote at C-1):
  - If 1: rx_data <= shreg and rx_valid=1 for exactly one cycle.
  - If 0: frame_err=1 for exactly one cycle; rx_data is unchanged.
  - Either way, go to IDLE immediately at mid-stop. This allows back-to-back frames with zero idle gap.
- Latency: rx_valid rises about 9*C + HALF + 3 clk after the first clk at which rx is low. The bench tolerance is +/-2 clk.
- Overrun: there is no handshake. rx_data holds until the next good frame, and each good frame overwrites it.
- rx_valid and frame_err are never high together.
- busy=1 from the cycle after start detection until the cycle after the STOP decision.
- Bit-rate tolerance: mid-bit sampling must receive correctly with a transmitter bit period within +/-3% of C. This includes C+2 = 106 clk.

Decomposition:
- Shared package uart_pkg holds:
  - rx_state_e enum: IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11.
  - DATA_BITS=8.
  - A function to compute CLKS_PER_BIT from CLK_FREQ and BAUD_RATE.
- One sub-module, uart_rx_sync: the 2-flop synchronizer plus edge flop. It outputs rx_s and fall_edge, resets to 1, and is reusable on other async inputs.
- The FSM, counters and voting live in uart_rx.

Test Plan:
- Reset: hold rst=1 for 5 clk with rx=1, then hold rx=1 for 2000 clk -> rx_data=00, rx_valid=0, frame_err=0, busy=0 throughout.
- Single frame: drive 0xA5 8N1 at 104 clk/bit -> exactly one rx_valid pulse with rx_data=0xA5, frame_err stays 0, busy falls within 3 clk of the pulse.
- Back-to-back: send 0x00, 0xFF, 0x3C with zero idle between the stop bit and the next start bit -> three rx_valid pulses in order with data 00, FF, 3C, and no frame_err.
- Glitch and noise:
  - Drive rx low for 20 clk, then high -> busy pulses for at most 55 clk, no rx_valid, no frame_err.
  - Send 0xC3 at 106 clk/bit with a 1-clk inverted spike at the mid-point of bit 2 -> rx_data=0xC3 with one rx_valid.
- Framing error: send 0x5A with stop bit 0, hold rx low for 300 clk, release high, then send 0x81 -> one frame_err pulse, no retrigger while low, rx_data stays 00, then rx_valid with 0x81.
- Reset mid-frame: assert rst for 1 clk during bit 4 of 0x77, then send 0x12 -> no pulse for 0x77, rx_valid with 0x12, busy=0 the cycle after reset.
